// File: rtl/ecc_mod_alu.sv
// ---------------------------------------------------------------------------
// ecc_mod_alu
//   Iterative modular arithmetic unit for the ECC datapath. Computes
//   (a+b) mod p, (a-b) mod p, (a*b) mod p and (a*a) mod p for a generic
//   operand width. ADD/SUB finish in one working cycle; MUL/SQR use an
//   MSB-first interleaved shift-add-reduce and take WIDTH working cycles.
//
//   Handshake: a request is accepted on a rising edge where in_valid and
//   in_ready are both high. in_ready is high only while idle, so in_valid
//   asserted at any other time is simply ignored (no queueing). out_valid is
//   a one-cycle pulse; result is held until the next out_valid.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      request strobe, sampled only while in_ready=1
//   mode       in   2      0=ADD, 1=SUB, 2=MUL, 3=SQR (b ignored)
//   a, b       in   WIDTH  operands, expected < p
//   p          in   WIDTH  modulus, expected >= 2
//   in_ready   out  1      high while idle
//   out_valid  out  1      one-cycle result strobe
//   result     out  WIDTH  last computed value mod p
// ---------------------------------------------------------------------------
module ecc_mod_alu #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ALU  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_sub;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_p;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_result;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH:0]     w_p_ext;
   logic [WIDTH:0]     w_add_sum;
   logic [WIDTH-1:0]   w_add_res;
   logic [WIDTH-1:0]   w_sub_res;
   logic [WIDTH-1:0]   w_alu_res;
   logic [WIDTH:0]     w_dbl;
   logic [WIDTH-1:0]   w_dbl_red;
   logic [WIDTH:0]     w_acc_sum;
   logic [WIDTH-1:0]   w_step_res;

   // ---------------------------------------------------------------------
   // ADD/SUB datapath. One extra bit holds the carry of a+b so the single
   // conditional subtraction of p is exact for any in-range operands.
   // ---------------------------------------------------------------------
   assign w_p_ext   = {1'b0, r_p};
   assign w_add_sum = {1'b0, r_a} + {1'b0, r_b};
   assign w_add_res = WIDTH'((w_add_sum >= w_p_ext) ? (w_add_sum - w_p_ext) : w_add_sum);
   assign w_sub_res = WIDTH'((r_a >= r_b) ? ({1'b0, r_a} - {1'b0, r_b})
                                          : ({1'b0, r_a} - {1'b0, r_b} + w_p_ext));
   assign w_alu_res = r_sub ? w_sub_res : w_add_res;

   // ---------------------------------------------------------------------
   // One multiplication step: R = 2R mod p, then R = R + a*b[cnt] mod p.
   // With R < p and a < p each partial sum is below 2p, so one subtraction
   // per substep is enough and WIDTH+1 bits never overflow.
   // ---------------------------------------------------------------------
   assign w_dbl      = {r_acc, 1'b0};
   assign w_dbl_red  = WIDTH'((w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl);
   assign w_acc_sum  = {1'b0, w_dbl_red} + (r_b[r_cnt] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
   assign w_step_res = WIDTH'((w_acc_sum >= w_p_ext) ? (w_acc_sum - w_p_ext) : w_acc_sum);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = mode[1] ? S_MUL : S_ALU;
            end
         end
         S_ALU: begin
            w_state_nxt = S_DONE;
         end
         S_MUL: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sub    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_p      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  // SQR reuses the MUL engine with b taken from a.
                  r_b   <= (mode == 2'd3) ? a : b;
                  r_p   <= p;
                  r_sub <= (mode == 2'd1);
                  r_acc <= '0;
                  r_cnt <= CNT_W'(WIDTH - 1);
               end
            end
            S_ALU: begin
               r_result <= w_alu_res;
            end
            S_MUL: begin
               // The final bit goes straight to result; r_acc is not needed after it.
               if (r_cnt == '0) begin
                  r_result <= w_step_res;
               end else begin
                  r_acc <= w_step_res;
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_ecc_mod_alu.sv
// ---------------------------------------------------------------------------
// tb_ecc_mod_alu
//   Two instances: WIDTH=8 for directed/random small-modulus traffic and
//   WIDTH=256 for P-256 style traffic. Expected results come from plain
//   modular arithmetic on wide vectors; handshake timing comes from the
//   documented latencies (1 working cycle for ADD/SUB, WIDTH for MUL/SQR).
// ---------------------------------------------------------------------------
module tb_ecc_mod_alu;

   localparam logic [255:0] P256 =
      256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [1:0] M_ADD = 2'd0;
   localparam logic [1:0] M_SUB = 2'd1;
   localparam logic [1:0] M_MUL = 2'd2;
   localparam logic [1:0] M_SQR = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst8, rst256;
   logic         in_valid8, in_valid256;
   logic [1:0]   mode8, mode256;
   logic [7:0]   a8, b8, p8;
   logic [255:0] a256, b256, p256;
   logic         in_ready8, out_valid8, in_ready256, out_valid256;
   logic [7:0]   result8;
   logic [255:0] result256;

   ecc_mod_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .in_valid(in_valid8), .mode(mode8),
      .a(a8), .b(b8), .p(p8),
      .in_ready(in_ready8), .out_valid(out_valid8), .result(result8)
   );

   ecc_mod_alu #(.WIDTH(256)) u_dut256 (
      .clk(clk), .rst(rst256), .in_valid(in_valid256), .mode(mode256),
      .a(a256), .b(b256), .p(p256),
      .in_ready(in_ready256), .out_valid(out_valid256), .result(result256)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   bit           chk_en   = 1'b0;
   int           busy_lo[2];
   int           busy_hi[2];
   logic [255:0] hold[2];
   logic [255:0] exp0_q[$];
   logic [255:0] exp1_q[$];
   int           due0_q[$];
   int           due1_q[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: plain modular arithmetic on 512-bit values.
   function automatic logic [255:0] model(input logic [1:0] m, input logic [255:0] a,
                                          input logic [255:0] b, input logic [255:0] p);
      logic [511:0] wa, wb, wp, r;
      wa = {256'd0, a};
      wb = {256'd0, b};
      wp = {256'd0, p};
      case (m)
         M_ADD:   r = (wa + wb) % wp;
         M_SUB:   r = (wa + wp - wb) % wp;
         M_MUL:   r = (wa * wb) % wp;
         default: r = (wa * wa) % wp;
      endcase
      return r[255:0];
   endfunction

   // ---------------- compare (every cycle) ----------------
   task automatic compare_dut(input int d, input logic rdy, input logic ov, input logic [255:0] res);
      logic  ev;
      string sfx;
      sfx = (d == 0) ? "8" : "256";
      if (d == 0) begin
         ev = (due0_q.size() > 0) && (due0_q[0] == cyc);
         if (ev) begin
            hold[0] = exp0_q.pop_front();
            void'(due0_q.pop_front());
         end
      end else begin
         ev = (due1_q.size() > 0) && (due1_q[0] == cyc);
         if (ev) begin
            hold[1] = exp1_q.pop_front();
            void'(due1_q.pop_front());
         end
      end
      check($sformatf("out_valid%s", sfx), {255'd0, ov}, {255'd0, ev});
      check($sformatf("result%s", sfx), res, hold[d]);
      check($sformatf("in_ready%s", sfx), {255'd0, rdy},
            {255'd0, !(cyc >= busy_lo[d] && cyc <= busy_hi[d])});
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         compare_dut(0, in_ready8, out_valid8, {248'd0, result8});
         compare_dut(1, in_ready256, out_valid256, result256);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input int d, input logic [1:0] m, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] p, input logic [255:0] exp);
      int lat;
      int n;
      lat = (m >= M_MUL) ? ((d == 0) ? 8 : 256) : 1;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (cyc >= busy_lo[d] && cyc <= busy_hi[d] && n < 2000);
      busy_lo[d] = cyc + 1;
      busy_hi[d] = cyc + 1 + lat;
      if (d == 0) begin
         exp0_q.push_back(exp);
         due0_q.push_back(cyc + 1 + lat);
         in_valid8 = 1'b1; mode8 = m; a8 = a[7:0]; b8 = b[7:0]; p8 = p[7:0];
      end else begin
         exp1_q.push_back(exp);
         due1_q.push_back(cyc + 1 + lat);
         in_valid256 = 1'b1; mode256 = m; a256 = a; b256 = b; p256 = p;
      end
      @(negedge clk);
      #1;
      // Operands are don't-care after acceptance; scramble them.
      if (d == 0) begin
         in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom);
         mode8 = 2'($urandom);
      end else begin
         in_valid256 = 1'b0; a256 = ~a256; b256 = ~b256; p256 = ~p256;
         mode256 = 2'($urandom);
      end
   endtask

   // Strobe in_valid for one cycle while the unit is known to be busy.
   task automatic pulse_busy(input int d);
      if (cyc >= busy_lo[d] && cyc <= busy_hi[d]) begin
         if (d == 0) begin
            in_valid8 = 1'b1; mode8 = M_ADD; a8 = 8'd7; b8 = 8'd9; p8 = 8'd251;
         end else begin
            in_valid256 = 1'b1; mode256 = M_ADD; a256 = 256'd7; b256 = 256'd9; p256 = P256;
         end
         @(negedge clk);
         #1;
         if (d == 0) in_valid8 = 1'b0;
         else        in_valid256 = 1'b0;
      end
   endtask

   // Reset the 8-bit unit on the 4th edge after a MUL acceptance.
   task automatic reset_mid_mul8();
      repeat (3) @(negedge clk);
      #1;
      rst8 = 1'b1;
      exp0_q.delete();
      due0_q.delete();
      hold[0]    = '0;
      busy_hi[0] = cyc;
      @(negedge clk);
      #1;
      rst8 = 1'b0;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0]   m;
      logic [255:0] ra, rb, rp;
      int           n;

      rst8 = 1'b1; rst256 = 1'b1;
      in_valid8 = 1'b0; in_valid256 = 1'b0;
      mode8 = '0; mode256 = '0;
      a8 = '0; b8 = '0; p8 = '0; a256 = '0; b256 = '0; p256 = '0;
      for (int i = 0; i < 2; i++) begin
         busy_lo[i] = 0;
         busy_hi[i] = -1;
         hold[i]    = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      rst8 = 1'b0; rst256 = 1'b0;
      chk_en = 1'b1;

      // Directed, 8-bit, p=251
      issue(0, M_ADD, 200, 100, 251, 49);
      issue(0, M_ADD, 0, 0, 251, 0);
      issue(0, M_SUB, 10, 20, 251, 241);
      issue(0, M_SUB, 20, 20, 251, 0);
      issue(0, M_MUL, 17, 23, 251, 140);
      issue(0, M_MUL, 17, 0, 251, 0);
      issue(0, M_SQR, 250, 77, 251, 1);
      issue(0, M_MUL, 3, 5, 251, 15);
      pulse_busy(0);
      issue(0, M_ADD, 1, 1, 251, 2);
      issue(0, M_SUB, 5, 3, 251, 2);
      pulse_busy(0);

      // Widest intermediate (p = 2^8-1) and smallest modulus
      issue(0, M_MUL, 254, 254, 255, 1);
      issue(0, M_ADD, 254, 254, 255, 253);
      issue(0, M_SUB, 0, 254, 255, 1);
      issue(0, M_MUL, 1, 1, 2, 1);
      issue(0, M_ADD, 1, 1, 2, 0);

      // Reset in the middle of a MUL, then a fresh ADD
      issue(0, M_MUL, 100, 200, 251, 171);
      reset_mid_mul8();
      issue(0, M_ADD, 1, 2, 251, 3);

      // 256-bit directed, P-256
      issue(1, M_MUL, P256 - 1, P256 - 1, P256, 256'd1);
      issue(1, M_ADD, P256 - 1, 256'd1, P256, 256'd0);
      issue(1, M_SQR, P256 - 1, 256'd12345, P256, 256'd1);

      // Random 8-bit traffic
      for (int i = 0; i < 200; i++) begin
         rp = 256'($urandom_range(2, 255));
         ra = 256'($urandom_range(0, int'(rp) - 1));
         rb = 256'($urandom_range(0, int'(rp) - 1));
         m  = 2'($urandom_range(0, 3));
         issue(0, m, ra, rb, rp, model(m, ra, rb, rp));
         if ($urandom_range(0, 3) == 0) pulse_busy(0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Random 256-bit traffic: P-256 and random moduli
      for (int i = 0; i < 12; i++) begin
         rp = (i < 8) ? P256 : (rand256() | 256'd2);
         ra = rand256() % rp;
         rb = rand256() % rp;
         m  = 2'($urandom_range(0, 3));
         issue(1, m, ra, rb, rp, model(m, ra, rb, rp));
         if (i == 3) pulse_busy(1);
      end

      // Drain outstanding results, bounded
      n = 0;
      while ((exp0_q.size() > 0 || exp1_q.size() > 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp0_q.size() > 0 || exp1_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp0_q.size() + exp1_q.size());
      end
      repeat (4) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
